port_tx_serializer: RTL and testbench
=====================================

// Module: port_tx_serializer
// PURPOSE
//  Downstream of the per-port deallocator: consumes its 64-bit packet word stream (ptx_*) and
//  serializes it onto a byte-wide GMII-style transmit interface toward the port MAC/PHY.
//  Generates preamble/SFD, inter-packet gap, and aborts (tx_er) on stream underrun or framing error.
//  One instance per port; only the ptx side uses the srdy/drdy handshake.
// PARAMETERS
//  PRE_LEN    7   preamble bytes (0x55) before SFD (0xD5); legal 1..15
//  IPG_BYTES  12  idle byte-times after each packet or abort; legal 1..63
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  ptx_srdy     in   1   word valid
//  ptx_drdy     out  1   word accepted when srdy & drdy
//  ptx_data     in   69  [63:0] data, byte0=[7:0] sent first; [64] SOP; [65] EOP; [68:66] EOP valid bytes-1
//  txd          out  8   transmit byte
//  tx_en        out  1   byte valid (preamble, SFD, data)
//  tx_er        out  1   abort marker, only with tx_en=1
// BEHAVIOUR
//  - Reset (sync, active-high): txd=0, tx_en=0, tx_er=0, ptx_drdy=0, state=S_IDLE, counters 0.
//    Reset mid-packet drops the packet immediately; no tx_er emitted.
//  - txd/tx_en/tx_er are flop outputs; ptx_drdy is combinational from state/counters only
//    (never from ptx_srdy) and is forced 0 while reset=1.
//  - S_IDLE: drdy=1. Word with SOP=1 -> latch word, S_PRE.
//    Word with SOP=0 -> discard, stay S_IDLE (counts a drop).
//  - S_PRE: PRE_LEN bytes of 0x55, then one 0xD5, tx_en=1, drdy=0.
//    Word accepted at cycle T -> first 0x55 at T+1, SFD at T+PRE_LEN+1,
//    byte0 at T+PRE_LEN+2 (T+9 default).
//  - S_DATA: one byte/cycle from held word, byte index 0..7 (3-bit counter).
//    Non-EOP word: drdy=1 only in the cycle byte 7 is driven.
//    If handshake completes, next word's byte0 follows with no bubble.
//    EOP word: bytes 0..N are driven (N=[68:66]), then S_IPG; drdy=0 for the whole EOP word.
//    SOP=1 and EOP=1 in one word is legal (single-word packet).
//  - Underrun: byte 7 of a non-EOP word driven and no handshake that cycle.
//    Next cycle: tx_en=1, tx_er=1, txd=0, then S_DISC.
//  - Framing error: new word in S_DATA has SOP=1.
//    Word is consumed and not transmitted; next cycle tx_en=1, tx_er=1, txd=0; then S_DISC.
//    Its EOP, if set, ends the discard.
//  - S_DISC: drdy=1, tx_en=0. Words are dropped until a word with EOP=1 is consumed, then S_IPG.
//    If the erroring word itself had EOP=1, go directly to S_IPG.
//  - S_IPG: tx_en=0, drdy=0 for exactly IPG_BYTES cycles, then S_IDLE.
//  - txd=0 whenever tx_en=0.
// CONFIGURATION
//  TX_STATS_EN defined: adds outputs
//    tx_pkt_cnt[31:0]: +1 per packet completed without tx_er
//    tx_byte_cnt[31:0]: +data bytes of those packets, excluding preamble and SFD
//    tx_err_cnt[15:0]: +1 per tx_er event or idle drop
//  All three wrap at max value and reset to 0.
//  TX_STATS_EN undefined: these ports and their logic are absent; the rest is unchanged.
// TESTING
//  1. SOP+EOP word, N=3, data 0x...44332211
//     -> 7x55, D5, 11 22 33 44; tx_en low 12 cycles; drdy high again after the IPG.
//  2. Three back-to-back words (SOP / mid / EOP N=7), srdy always high
//     -> 24 contiguous data bytes, no bubble; drdy high only on each byte-7 cycle.
//  3. Second word withheld until 2 cycles after byte 7
//     -> tx_er pulse 1 cycle; later words dropped through EOP; 12-cycle IPG; tx_err_cnt=1.
//  4. Non-SOP word in idle, then valid 1-word packet
//     -> first word dropped, no tx_en; packet sent normally.
//  5. Reset asserted during data byte 3
//     -> next cycle tx_en=0, drdy=0; after release, the next SOP packet is sent cleanly.
//  6. TX_STATS_EN: 2 good packets of 8 and 13 bytes
//     -> tx_pkt_cnt=2, tx_byte_cnt=21, tx_err_cnt=0.

Source files
------------

// File: rtl/port_tx_serializer.sv
// port_tx_serializer: 64-bit ptx word stream to byte-wide GMII-style transmit with preamble/SFD, IPG and aborts.
// Define TX_STATS_EN to add the tx_pkt_cnt / tx_byte_cnt / tx_err_cnt statistics outputs.
module port_tx_serializer #(
    parameter int unsigned PRE_LEN   = 7,
    parameter int unsigned IPG_BYTES = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ptx_srdy,
    output logic        ptx_drdy,
    input  logic [68:0] ptx_data,
    output logic [7:0]  txd,
    output logic        tx_en,
    output logic        tx_er
`ifdef TX_STATS_EN
    ,
    output logic [31:0] tx_pkt_cnt,
    output logic [31:0] tx_byte_cnt,
    output logic [15:0] tx_err_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_ERR, S_DISC, S_IPG} state_t;

    localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);
    localparam logic [5:0] PRE_SFD  = 6'(PRE_LEN);
    localparam logic [5:0] IPG_LAST = 6'(IPG_BYTES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] data_q, data_d;
    logic        eop_q, eop_d;
    logic [2:0]  nlast_q, nlast_d;
    logic        err_eop_q, err_eop_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d;
    logic        er_q, er_d;

    logic        hs;
    logic        in_sop;
    logic        in_eop;
    logic [2:0]  idx_nxt;

    assign in_sop  = ptx_data[64];
    assign in_eop  = ptx_data[65];
    assign hs      = ptx_srdy & ptx_drdy;
    assign idx_nxt = idx_q + 3'd1;

    always_comb begin
        ptx_drdy = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE, S_DISC: ptx_drdy = 1'b1;
                S_DATA:         ptx_drdy = (idx_q == 3'd7) && !eop_q;
                default:        ptx_drdy = 1'b0;
            endcase
        end
    end

    // Outputs are computed one cycle ahead and registered, so state_q describes the byte now on txd.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        eop_d     = eop_q;
        nlast_d   = nlast_q;
        err_eop_d = err_eop_q;
        txd_d     = '0;
        en_d      = 1'b0;
        er_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs && in_sop) begin
                    data_d  = ptx_data[63:0];
                    eop_d   = in_eop;
                    nlast_d = ptx_data[68:66];
                    cnt_d   = '0;
                    txd_d   = 8'h55;
                    en_d    = 1'b1;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                en_d = 1'b1;
                if (cnt_q == PRE_SFD) begin
                    txd_d   = data_q[7:0];
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    txd_d = (cnt_q == PRE_LAST) ? 8'hD5 : 8'h55;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DATA: begin
                if (eop_q && (idx_q == nlast_q)) begin
                    cnt_d   = '0;
                    state_d = S_IPG;
                end else if (idx_q != 3'd7) begin
                    en_d  = 1'b1;
                    txd_d = data_q[{idx_nxt, 3'b000} +: 8];
                    idx_d = idx_nxt;
                end else if (hs && !in_sop) begin
                    data_d  = ptx_data[63:0];
                    eop_d   = in_eop;
                    nlast_d = ptx_data[68:66];
                    en_d    = 1'b1;
                    txd_d   = ptx_data[7:0];
                    idx_d   = '0;
                end else begin
                    // Underrun, or a framing error whose own EOP closes the discard immediately.
                    en_d      = 1'b1;
                    er_d      = 1'b1;
                    err_eop_d = hs && in_eop;
                    state_d   = S_ERR;
                end
            end
            S_ERR: begin
                cnt_d   = '0;
                state_d = err_eop_q ? S_IPG : S_DISC;
            end
            S_DISC: begin
                if (hs && in_eop) begin
                    cnt_d   = '0;
                    state_d = S_IPG;
                end
            end
            S_IPG: begin
                if (cnt_q == IPG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            eop_q     <= 1'b0;
            nlast_q   <= '0;
            err_eop_q <= 1'b0;
            txd_q     <= '0;
            en_q      <= 1'b0;
            er_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            eop_q     <= eop_d;
            nlast_q   <= nlast_d;
            err_eop_q <= err_eop_d;
            txd_q     <= txd_d;
            en_q      <= en_d;
            er_q      <= er_d;
        end
    end

    assign txd   = txd_q;
    assign tx_en = en_q;
    assign tx_er = er_q;

`ifdef TX_STATS_EN
    logic [31:0] pkt_q, byte_q, acc_q;
    logic [15:0] err_q;
    logic        sop_start, word_adv, pkt_done, err_evt;

    assign sop_start = (state_q == S_IDLE) && hs && in_sop;
    assign word_adv  = (state_q == S_DATA) && hs && !in_sop;
    assign pkt_done  = (state_q == S_DATA) && eop_q && (idx_q == nlast_q);
    assign err_evt   = er_d || ((state_q == S_IDLE) && hs && !in_sop);

    // acc_q holds the bytes of completed non-EOP words of the packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q  <= '0;
            byte_q <= '0;
            acc_q  <= '0;
            err_q  <= '0;
        end else begin
            if (sop_start) begin
                acc_q <= '0;
            end else if (word_adv) begin
                acc_q <= acc_q + 32'd8;
            end
            if (pkt_done) begin
                pkt_q  <= pkt_q + 32'd1;
                byte_q <= byte_q + acc_q + {29'd0, nlast_q} + 32'd1;
            end
            if (err_evt) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign tx_pkt_cnt  = pkt_q;
    assign tx_byte_cnt = byte_q;
    assign tx_err_cnt  = err_q;
`endif

endmodule

// File: tb/tb_port_tx_serializer.sv
// Directed self-checking bench for port_tx_serializer (default PRE_LEN=7, IPG_BYTES=12).
// Statistics checks are compiled in when TX_STATS_EN is defined.
module tb_port_tx_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ptx_srdy;
    logic        ptx_drdy;
    logic [68:0] ptx_data;
    logic [7:0]  txd;
    logic        tx_en;
    logic        tx_er;
`ifdef TX_STATS_EN
    logic [31:0] tx_pkt_cnt;
    logic [31:0] tx_byte_cnt;
    logic [15:0] tx_err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    port_tx_serializer #(.PRE_LEN(7), .IPG_BYTES(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .ptx_srdy (ptx_srdy),
        .ptx_drdy (ptx_drdy),
        .ptx_data (ptx_data),
        .txd      (txd),
        .tx_en    (tx_en),
        .tx_er    (tx_er)
`ifdef TX_STATS_EN
        ,
        .tx_pkt_cnt  (tx_pkt_cnt),
        .tx_byte_cnt (tx_byte_cnt),
        .tx_err_cnt  (tx_err_cnt)
`endif
    );

    function automatic logic [68:0] mk(input logic sop, input logic eop, input logic [2:0] n,
                                       input logic [63:0] d);
        return {n, eop, sop, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset    = 1'b1;
        ptx_srdy = 1'b0;
        ptx_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        ptx_srdy = 1'b1;
        ptx_data = mk(1'b1, 1'b1, 3'd0, 64'h1);
        #1;
        if (ptx_drdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drdy_comb got=%b exp=0", ptx_drdy);
        end
        n_checks++;
        tick;
        tick;
        if ({tx_en, tx_er, txd, ptx_drdy} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs got en=%b er=%b txd=%h drdy=%b exp 0 0 00 0",
                     tx_en, tx_er, txd, ptx_drdy);
        end
        n_checks++;
`ifdef TX_STATS_EN
        if ({tx_pkt_cnt, tx_byte_cnt, tx_err_cnt} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_stats got pkt=%0d byte=%0d err=%0d exp 0 0 0",
                     tx_pkt_cnt, tx_byte_cnt, tx_err_cnt);
        end
        n_checks++;
`endif
        ptx_srdy = 1'b0;
        reset    = 1'b0;
        #1;
        if (ptx_drdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_drdy got=%b exp=1", ptx_drdy);
        end
        n_checks++;
    endtask

    task automatic test_single_word;
        logic [63:0] d;
        logic [7:0]  e_txd;
        logic        e_en, e_dr;
        d = 64'h0000_0000_4433_2211;
        apply_reset;
        ptx_data = mk(1'b1, 1'b1, 3'd3, d);
        ptx_srdy = 1'b1;
        if (ptx_drdy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle_drdy got=%b exp=1", ptx_drdy);
        end
        n_checks++;
        tick;
        ptx_srdy = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            e_en = 1'b0; e_txd = 8'h00; e_dr = 1'b0;
            if (c <= 7) begin
                e_en = 1'b1; e_txd = 8'h55;
            end else if (c == 8) begin
                e_en = 1'b1; e_txd = 8'hD5;
            end else if (c <= 12) begin
                e_en = 1'b1; e_txd = d[8*(c-9) +: 8];
            end else if (c == 25) begin
                e_dr = 1'b1;
            end
            if ({tx_en, tx_er, txd, ptx_drdy} !== {e_en, 1'b0, e_txd, e_dr}) begin
                n_fail++;
                $display("FAIL single c=%0d got en=%b er=%b txd=%h drdy=%b exp en=%b er=0 txd=%h drdy=%b",
                         c, tx_en, tx_er, txd, ptx_drdy, e_en, e_txd, e_dr);
            end
            n_checks++;
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [68:0] words [3];
        logic [63:0] d;
        logic [7:0]  e_txd;
        logic        e_en, e_dr, hs;
        int          wi;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'(8*w + b + 1);
            words[w] = mk(w == 0, w == 2, 3'd7, d);
        end
        apply_reset;
        wi       = 0;
        ptx_data = words[0];
        ptx_srdy = 1'b1;
        for (int c = 0; c <= 33; c++) begin
            e_en = 1'b0; e_txd = 8'h00; e_dr = 1'b0;
            if (c == 0) begin
                e_dr = 1'b1;
            end else if (c <= 7) begin
                e_en = 1'b1; e_txd = 8'h55;
            end else if (c == 8) begin
                e_en = 1'b1; e_txd = 8'hD5;
            end else if (c <= 32) begin
                e_en  = 1'b1;
                e_txd = 8'(c - 8);
                e_dr  = (c - 9 == 7) || (c - 9 == 15);
            end
            if ({tx_en, tx_er, txd, ptx_drdy} !== {e_en, 1'b0, e_txd, e_dr}) begin
                n_fail++;
                $display("FAIL b2b c=%0d got en=%b er=%b txd=%h drdy=%b exp en=%b er=0 txd=%h drdy=%b",
                         c, tx_en, tx_er, txd, ptx_drdy, e_en, e_txd, e_dr);
            end
            n_checks++;
            hs = ptx_srdy & ptx_drdy;
            tick;
            if (hs) begin
                wi++;
                if (wi < 3) ptx_data = words[wi];
                else        ptx_srdy = 1'b0;
            end
        end
    endtask

    task automatic test_underrun;
        logic [7:0] e_txd;
        logic       e_en, e_er, e_dr;
        apply_reset;
        ptx_data = mk(1'b1, 1'b0, 3'd7, 64'hA7A6_A5A4_A3A2_A1A0);
        ptx_srdy = 1'b1;
        tick;
        ptx_srdy = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c == 18) begin
                ptx_data = mk(1'b0, 1'b0, 3'd7, 64'hB7B6_B5B4_B3B2_B1B0);
                ptx_srdy = 1'b1;
            end else if (c == 19) begin
                ptx_data = mk(1'b0, 1'b1, 3'd2, 64'h0000_0000_00C2_C1C0);
            end else if (c == 20) begin
                ptx_srdy = 1'b0;
            end
            e_en = 1'b0; e_er = 1'b0; e_txd = 8'h00; e_dr = 1'b0;
            if (c <= 7) begin
                e_en = 1'b1; e_txd = 8'h55;
            end else if (c == 8) begin
                e_en = 1'b1; e_txd = 8'hD5;
            end else if (c <= 16) begin
                e_en = 1'b1; e_txd = 8'hA0 + 8'(c - 9); e_dr = (c == 16);
            end else if (c == 17) begin
                e_en = 1'b1; e_er = 1'b1;
            end else if (c == 18 || c == 19 || c == 32) begin
                e_dr = 1'b1;
            end
            if ({tx_en, tx_er, txd, ptx_drdy} !== {e_en, e_er, e_txd, e_dr}) begin
                n_fail++;
                $display("FAIL underrun c=%0d got en=%b er=%b txd=%h drdy=%b exp en=%b er=%b txd=%h drdy=%b",
                         c, tx_en, tx_er, txd, ptx_drdy, e_en, e_er, e_txd, e_dr);
            end
            n_checks++;
            tick;
        end
`ifdef TX_STATS_EN
        if ({tx_pkt_cnt, tx_err_cnt} !== {32'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL underrun_stats got pkt=%0d err=%0d exp pkt=0 err=1", tx_pkt_cnt, tx_err_cnt);
        end
        n_checks++;
`endif
    endtask

    task automatic test_framing;
        logic [7:0] e_txd;
        logic       e_en, e_er, e_dr;
        apply_reset;
        ptx_data = mk(1'b1, 1'b0, 3'd7, 64'h0706_0504_0302_0100);
        ptx_srdy = 1'b1;
        tick;
        ptx_data = mk(1'b1, 1'b1, 3'd7, 64'hEEEE_EEEE_EEEE_EEEE);
        for (int c = 1; c <= 31; c++) begin
            e_en = 1'b0; e_er = 1'b0; e_txd = 8'h00; e_dr = 1'b0;
            if (c <= 7) begin
                e_en = 1'b1; e_txd = 8'h55;
            end else if (c == 8) begin
                e_en = 1'b1; e_txd = 8'hD5;
            end else if (c <= 16) begin
                e_en = 1'b1; e_txd = 8'(c - 9); e_dr = (c == 16);
            end else if (c == 17) begin
                e_en = 1'b1; e_er = 1'b1;
            end else if (c == 30 || c == 31) begin
                e_dr = 1'b1;
            end
            if ({tx_en, tx_er, txd, ptx_drdy} !== {e_en, e_er, e_txd, e_dr}) begin
                n_fail++;
                $display("FAIL framing c=%0d got en=%b er=%b txd=%h drdy=%b exp en=%b er=%b txd=%h drdy=%b",
                         c, tx_en, tx_er, txd, ptx_drdy, e_en, e_er, e_txd, e_dr);
            end
            n_checks++;
            if (c == 16) ptx_srdy = 1'b1;
            tick;
            if (c == 16) ptx_srdy = 1'b0;
        end
    endtask

    task automatic test_idle_drop;
        logic [7:0] e_txd;
        logic       e_en;
        apply_reset;
        ptx_data = mk(1'b0, 1'b1, 3'd7, 64'h1234_5678_9ABC_DEF0);
        ptx_srdy = 1'b1;
        tick;
        ptx_srdy = 1'b0;
        if ({tx_en, txd, ptx_drdy} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_drop got en=%b txd=%h drdy=%b exp en=0 txd=00 drdy=1", tx_en, txd, ptx_drdy);
        end
        n_checks++;
`ifdef TX_STATS_EN
        if (tx_err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL idle_drop_err_cnt got=%0d exp=1", tx_err_cnt);
        end
        n_checks++;
`endif
        ptx_data = mk(1'b1, 1'b1, 3'd0, 64'h0000_0000_0000_00AB);
        ptx_srdy = 1'b1;
        tick;
        ptx_srdy = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            e_en  = (c <= 9);
            e_txd = (c <= 7) ? 8'h55 : (c == 8) ? 8'hD5 : (c == 9) ? 8'hAB : 8'h00;
            if ({tx_en, tx_er, txd} !== {e_en, 1'b0, e_txd}) begin
                n_fail++;
                $display("FAIL idle_pkt c=%0d got en=%b er=%b txd=%h exp en=%b er=0 txd=%h",
                         c, tx_en, tx_er, txd, e_en, e_txd);
            end
            n_checks++;
            tick;
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] e_txd;
        logic       e_en;
        apply_reset;
        ptx_data = mk(1'b1, 1'b0, 3'd7, 64'h7766_5544_3322_1100);
        ptx_srdy = 1'b1;
        tick;
        ptx_srdy = 1'b0;
        repeat (11) tick;
        if ({tx_en, txd} !== {1'b1, 8'h33}) begin
            n_fail++;
            $display("FAIL rstmid_byte3 got en=%b txd=%h exp en=1 txd=33", tx_en, txd);
        end
        n_checks++;
        reset = 1'b1;
        tick;
        if ({tx_en, tx_er, txd, ptx_drdy} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_after got en=%b er=%b txd=%h drdy=%b exp 0 0 00 0",
                     tx_en, tx_er, txd, ptx_drdy);
        end
        n_checks++;
        reset = 1'b0;
        #1;
        ptx_data = mk(1'b1, 1'b1, 3'd1, 64'h0000_0000_0000_BBAA);
        ptx_srdy = 1'b1;
        if (ptx_drdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_drdy got=%b exp=1", ptx_drdy);
        end
        n_checks++;
        tick;
        ptx_srdy = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            e_en  = (c <= 10);
            e_txd = (c <= 7) ? 8'h55 : (c == 8) ? 8'hD5 : (c == 9) ? 8'hAA : (c == 10) ? 8'hBB : 8'h00;
            if ({tx_en, tx_er, txd} !== {e_en, 1'b0, e_txd}) begin
                n_fail++;
                $display("FAIL rstmid_pkt c=%0d got en=%b er=%b txd=%h exp en=%b er=0 txd=%h",
                         c, tx_en, tx_er, txd, e_en, e_txd);
            end
            n_checks++;
            tick;
        end
    endtask

`ifdef TX_STATS_EN
    task automatic test_stats;
        logic hs;
        apply_reset;
        ptx_data = mk(1'b1, 1'b1, 3'd7, 64'h0807_0605_0403_0201);
        ptx_srdy = 1'b1;
        tick;
        ptx_srdy = 1'b0;
        repeat (30) tick;
        ptx_data = mk(1'b1, 1'b0, 3'd7, 64'h1111_1111_1111_1111);
        ptx_srdy = 1'b1;
        tick;
        ptx_data = mk(1'b0, 1'b1, 3'd4, 64'h0000_0022_2222_2222);
        for (int c = 0; c < 40; c++) begin
            hs = ptx_srdy & ptx_drdy;
            tick;
            if (hs) ptx_srdy = 1'b0;
        end
        if ({tx_pkt_cnt, tx_byte_cnt, tx_err_cnt} !== {32'd2, 32'd21, 16'd0}) begin
            n_fail++;
            $display("FAIL stats got pkt=%0d byte=%0d err=%0d exp pkt=2 byte=21 err=0",
                     tx_pkt_cnt, tx_byte_cnt, tx_err_cnt);
        end
        n_checks++;
    endtask
`endif

    initial begin
        reset    = 1'b1;
        ptx_srdy = 1'b0;
        ptx_data = '0;
        test_reset;
        test_single_word;
        test_back_to_back;
        test_underrun;
        test_framing;
        test_idle_drop;
        test_reset_mid;
`ifdef TX_STATS_EN
        test_stats;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
